qynq_led_driver: RTL and testbench



---
 rtl/qynq_led_driver.sv | 201 ++++++++++++++++++++
 tb/tb_qynq_led_driver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/qynq_led_driver.sv
// qynq_led_driver: LED pattern engine driven by one PS GPIO bit.
//
// The GPIO bit is treated as an asynchronous "next mode" button. It is
// synchronised, debounced, and each accepted rising edge steps a five-mode
// sequencer: OFF, ON, BLINK, CHASE, BREATH.
//
// Ports:
//   clk      PL fabric clock, single clock domain
//   rst_n    asynchronous active-low reset
//   gpio_in  PS GPIO output bit, asynchronous to clk
//   led[3:0] LED drive, 1 = lit (registered)
//   mode[2:0] current mode code (0 OFF, 1 ON, 2 BLINK, 3 CHASE, 4 BREATH)
module qynq_led_driver #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned FILT_LEN   = 16,
  parameter int unsigned STEP_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gpio_in,
  output logic [3:0] led,
  output logic [2:0] mode
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  localparam logic [TW-1:0] TickMax = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FiltMax = FW'(FILT_LEN - 1);
  localparam logic [SW-1:0] StepMax = SW'(STEP_TICKS - 1);

  typedef enum logic [2:0] {
    StOff    = 3'd0,
    StOn     = 3'd1,
    StBlink  = 3'd2,
    StChase  = 3'd3,
    StBreath = 3'd4
  } mode_e;

  // Input conditioning
  logic          sync1_q;
  logic          gpio_s;
  logic [FW-1:0] filt_cnt_q;
  logic          filt_q;
  logic          filt_prev_q;
  logic          adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      gpio_s  <= 1'b0;
    end else begin
      sync1_q <= gpio_in;
      gpio_s  <= sync1_q;
    end
  end

  // A level change is accepted only after FILT_LEN consecutive differing samples;
  // any matching sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt_q  <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
    end else begin
      filt_prev_q <= filt_q;
      if (gpio_s == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FiltMax) begin
        filt_q     <= gpio_s;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FW'(1);
      end
    end
  end

  assign adv = filt_q & ~filt_prev_q;

  // Base tick and step
  logic [TW-1:0] tick_cnt_q;
  logic [SW-1:0] step_cnt_q;
  logic          tick;
  logic          step;

  assign tick = (tick_cnt_q == TickMax);
  assign step = tick && (step_cnt_q == StepMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  // The tick phase is free-running; only the step phase restarts on a mode change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
    end else if (adv) begin
      step_cnt_q <= '0;
    end else if (tick) begin
      step_cnt_q <= step ? '0 : step_cnt_q + SW'(1);
    end
  end

  // Mode sequencer
  mode_e mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= StOff;
    end else begin
      case (mode_q)
        StOff:    if (adv) mode_q <= StOn;
        StOn:     if (adv) mode_q <= StBlink;
        StBlink:  if (adv) mode_q <= StChase;
        StChase:  if (adv) mode_q <= StBreath;
        StBreath: if (adv) mode_q <= StOff;
        default:  mode_q <= StOff;
      endcase
    end
  end

  // Pattern state; a mode change reinitialises it and suppresses any
  // coincident step/tick.
  logic       blink_q;
  logic [3:0] chase_q;
  logic [7:0] duty_q;
  logic       dir_down_q;
  logic [7:0] pwm_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q    <= 1'b0;
      chase_q    <= 4'b0000;
      duty_q     <= 8'd0;
      dir_down_q <= 1'b0;
    end else if (adv) begin
      blink_q    <= 1'b1;
      chase_q    <= 4'b0001;
      duty_q     <= 8'd0;
      dir_down_q <= 1'b0;
    end else begin
      case (mode_q)
        StBlink: begin
          if (step) blink_q <= ~blink_q;
        end
        StChase: begin
          if (step) chase_q <= {chase_q[2:0], chase_q[3]};
        end
        StBreath: begin
          if (tick) begin
            if (!dir_down_q) begin
              duty_q <= duty_q + 8'd1;
              if (duty_q == 8'd254) dir_down_q <= 1'b1;
            end else begin
              duty_q <= duty_q - 8'd1;
              if (duty_q == 8'd1) dir_down_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= 8'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end

  // Registered LED output
  logic [3:0] led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= 4'h0;
    end else begin
      case (mode_q)
        StOff:    led_q <= 4'h0;
        StOn:     led_q <= 4'hF;
        StBlink:  led_q <= {4{blink_q}};
        StChase:  led_q <= chase_q;
        StBreath: led_q <= {4{pwm_cnt_q < duty_q}};
        default:  led_q <= 4'h0;
      endcase
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_qynq_led_driver.sv
// Scoreboard bench for qynq_led_driver. Stimulus pushes per-cycle expected
// {led, mode} entries keyed by edge count since reset release; a monitor pops
// and compares them on the falling clock edge.
module tb_qynq_led_driver;

  localparam int TICK_DIV   = 4;
  localparam int FILT_LEN   = 4;
  localparam int STEP_TICKS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gpio_in = 1'b0;
  logic [3:0] led;
  logic [2:0] mode;

  always #5 clk = ~clk;

  qynq_led_driver #(
    .TICK_DIV  (TICK_DIV),
    .FILT_LEN  (FILT_LEN),
    .STEP_TICKS(STEP_TICKS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .gpio_in(gpio_in),
    .led    (led),
    .mode   (mode)
  );

  // Rising edges seen since reset was last released.
  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [3:0] led;
    logic [2:0] mode;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   chg_e[$];   // edge at which mode register takes a new value
  int   chg_m[$];

  task automatic check(input string name, input logic [3:0] al, input logic [2:0] am,
                       input logic [3:0] el, input logic [2:0] em);
    n_checks++;
    if (al !== el || am !== em) begin
      n_errors++;
      $display("FAIL %s: got led=%b mode=%0d, expected led=%b mode=%0d", name, al, am, el, em);
    end
  endtask

  function automatic void mode_at(input int e, output int m, output int me);
    m  = 0;
    me = 0;
    foreach (chg_e[i]) begin
      if (chg_e[i] <= e) begin
        m  = chg_m[i];
        me = chg_e[i];
      end
    end
  endfunction

  // LED value computed from the state held after edge e.
  function automatic logic [3:0] pat(input int e);
    int m, me, t, s, d;
    mode_at(e, m, me);
    t = e / TICK_DIV - me / TICK_DIV;  // ticks land on edges that are multiples of TICK_DIV
    s = t / STEP_TICKS;
    d = t % 510;
    if (d > 255) d = 510 - d;
    case (m)
      1:       return 4'hF;
      2:       return (s % 2 == 0) ? 4'hF : 4'h0;
      3:       return 4'b0001 << (s % 4);
      4:       return ((e % 256) < d) ? 4'hF : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  task automatic sb_push(input int c, input logic [3:0] l, input logic [2:0] m);
    exp_t x;
    int   i;
    x.cyc  = c;
    x.led  = l;
    x.mode = m;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, x);
  endtask

  task automatic push_range(input int a, input int b);
    int m, me;
    for (int n = a; n <= b; n++) begin
      mode_at(n, m, me);
      sb_push(n, pat(n - 1), 3'(m));
    end
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called on a falling edge: hold gpio_in high for len cycles, run span cycles total.
  // First high sample is edge c+1; mode moves on edge c+1+FILT_LEN+2.
  task automatic seg(input int len, input int span);
    int c, m, me;
    c = cyc;
    if (len >= FILT_LEN) begin
      mode_at(c, m, me);
      chg_e.push_back(c + 1 + FILT_LEN + 2);
      chg_m.push_back((m + 1) % 5);
    end
    push_range(c + 1, c + span);
    if (len > 0) begin
      gpio_in = 1'b1;
      repeat (len) @(negedge clk);
      gpio_in = 1'b0;
    end
    goto_cyc(c + span);
  endtask

  // Monitor
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front();
        if (x.cyc < cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL missed_c%0d: got no sample at cycle %0d, expected one", x.cyc, x.cyc);
        end else begin
          check($sformatf("c%0d", x.cyc), led, mode, x.led, x.mode);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    gpio_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Hand-derived spot values
    sb_push(107,  4'h0,    3'd0);  // one edge before ON
    sb_push(108,  4'h0,    3'd1);  // mode first shows ON
    sb_push(109,  4'hF,    3'd1);  // led follows one cycle later
    sb_push(181,  4'hF,    3'd2);  // BLINK starts lit
    sb_push(189,  4'h0,    3'd2);  // after 8 lit cycles
    sb_push(197,  4'hF,    3'd2);
    sb_push(229,  4'b0001, 3'd3);  // CHASE
    sb_push(237,  4'b0010, 3'd3);
    sb_push(253,  4'b1000, 3'd3);
    sb_push(261,  4'b0001, 3'd3);  // wrap
    sb_push(276,  4'b0010, 3'd4);  // press coincides with a chase step
    sb_push(277,  4'h0,    3'd4);  // BREATH starts at duty 0
    sb_push(1297, 4'hF,    3'd4);  // duty 255
    sb_push(2317, 4'h0,    3'd4);  // back to duty 0
    sb_push(2409, 4'h0,    3'd0);  // OFF again

    seg(0, 101);    // idle
    seg(20, 48);    // long press -> ON, release ignored
    seg(3, 24);     // 3-cycle glitch, no change
    seg(4, 48);     // -> BLINK at edge 180
    seg(4, 48);     // -> CHASE at edge 228
    seg(4, 2132);   // -> BREATH at edge 276, full triangle and beyond
    seg(4, 32);     // -> OFF
    seg(4, 20);     // -> ON
    seg(4, 12);     // -> BLINK at 2460, now at 2465 in lit phase

    check("pre_reset", led, mode, 4'hF, 3'd2);
    #2 rst_n = 1'b0;
    #1 check("async_reset", led, mode, 4'h0, 3'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chg_e.delete();
    chg_m.delete();
    seg(0, 20);
    @(negedge clk);

    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
